// File: rtl/pad_bidir_ctrl.sv
// Core-side controller for an array of bidirectional pad cells: sequences output
// enables through a bus-turnaround gap and synchronises/glitch-filters pad inputs.
module pad_bidir_ctrl #(
  parameter int NumPads    = 4,
  parameter int SyncStages = 2,
  parameter int FiltCycles = 3,
  parameter int TurnCycles = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumPads-1:0] out_en_i,
  input  logic [NumPads-1:0] out_val_i,
  output logic [NumPads-1:0] pad_din_o,
  output logic [NumPads-1:0] pad_oen_o,
  input  logic [NumPads-1:0] pad_dout_i,
  output logic [NumPads-1:0] in_val_o,
  output logic [NumPads-1:0] in_rise_o,
  output logic [NumPads-1:0] in_fall_o,
  output logic [NumPads-1:0] driving_o
);

  localparam int TW = (TurnCycles > 0) ? $clog2(TurnCycles + 1) : 1;
  localparam int CW = $clog2(FiltCycles + 1);

  typedef enum logic [1:0] {
    ST_HIZ   = 2'd0,
    ST_TURN  = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  state_e                state_q [NumPads];
  state_e                state_d [NumPads];
  logic [TW-1:0]         turn_q  [NumPads];
  logic [TW-1:0]         turn_d  [NumPads];
  logic [SyncStages-1:0] sync_q  [NumPads];
  logic [SyncStages-1:0] sync_d  [NumPads];
  logic [CW-1:0]         filt_q  [NumPads];
  logic [CW-1:0]         filt_d  [NumPads];

  logic [NumPads-1:0] din_q, din_d;
  logic [NumPads-1:0] oen_q, oen_d;
  logic [NumPads-1:0] drv_q, drv_d;
  logic [NumPads-1:0] in_val_q, in_val_d;
  logic [NumPads-1:0] rise_q, rise_d;
  logic [NumPads-1:0] fall_q, fall_d;

  // Output enable and driving flag follow the registered state, so driving starts
  // one cycle after the FSM reaches DRIVE and releases one cycle after it leaves.
  always_comb begin
    din_d    = out_val_i;
    oen_d    = '1;
    drv_d    = '0;
    in_val_d = in_val_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < NumPads; i++) begin
      state_d[i] = state_q[i];
      turn_d[i]  = turn_q[i];
      sync_d[i]  = {sync_q[i][SyncStages-2:0], pad_dout_i[i]};
      filt_d[i]  = filt_q[i];

      oen_d[i] = (state_q[i] != ST_DRIVE);
      drv_d[i] = (state_q[i] == ST_DRIVE);

      case (state_q[i])
        ST_HIZ: begin
          if (out_en_i[i]) begin
            if (TurnCycles == 0) begin
              state_d[i] = ST_DRIVE;
            end else begin
              state_d[i] = ST_TURN;
              turn_d[i]  = TW'(TurnCycles);
            end
          end
        end
        ST_TURN: begin
          if (!out_en_i[i]) begin
            state_d[i] = ST_HIZ;
          end else if (turn_q[i] == TW'(1)) begin
            state_d[i] = ST_DRIVE;
          end else begin
            turn_d[i] = turn_q[i] - TW'(1);
          end
        end
        ST_DRIVE: begin
          if (!out_en_i[i]) begin
            state_d[i] = ST_HIZ;
          end
        end
        default: state_d[i] = ST_HIZ;
      endcase

      // Accept on the cycle the run of differing samples reaches FiltCycles.
      if (sync_q[i][SyncStages-1] == in_val_q[i]) begin
        filt_d[i] = '0;
      end else if (filt_q[i] >= CW'(FiltCycles - 1)) begin
        filt_d[i]   = '0;
        in_val_d[i] = sync_q[i][SyncStages-1];
        rise_d[i]   = sync_q[i][SyncStages-1];
        fall_d[i]   = ~sync_q[i][SyncStages-1];
      end else begin
        filt_d[i] = filt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      din_q    <= '0;
      oen_q    <= '1;
      drv_q    <= '0;
      in_val_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < NumPads; i++) begin
        state_q[i] <= ST_HIZ;
        turn_q[i]  <= '0;
        sync_q[i]  <= '0;
        filt_q[i]  <= '0;
      end
    end else begin
      din_q    <= din_d;
      oen_q    <= oen_d;
      drv_q    <= drv_d;
      in_val_q <= in_val_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < NumPads; i++) begin
        state_q[i] <= state_d[i];
        turn_q[i]  <= turn_d[i];
        sync_q[i]  <= sync_d[i];
        filt_q[i]  <= filt_d[i];
      end
    end
  end

  assign pad_din_o = din_q;
  assign pad_oen_o = oen_q;
  assign driving_o = drv_q;
  assign in_val_o  = in_val_q;
  assign in_rise_o = rise_q;
  assign in_fall_o = fall_q;

endmodule
